// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: computes a WIDTH-bit add by stepping one external 4-bit
// ripple-carry slice (adder4) across the operands, least-significant nibble
// first. Operands are taken on a valid/ready handshake, and the result is
// offered on a valid/ready handshake.
// Optional feature macro: SUB_MODE_EN adds a 'sub' input. When sub=1 the
// block computes a - b, and cout=1 means "no borrow".
module adder_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SUB_MODE_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic [3:0]       slice_a,
    output logic [3:0]       slice_b,
    output logic             slice_cin,
    input  logic [3:0]       slice_s,
    input  logic             slice_cout
);

    localparam int NSLICE = WIDTH / 4;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDX_W-1:0] idx;
    logic             carry_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
`ifdef SUB_MODE_EN
    logic             sub_q;
`endif

    // in_ready is suppressed while reset is held, even though the state is
    // already IDLE.
    assign in_ready  = (state == IDLE) && rst_n;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;

    // Present the current nibble pair to the slice during RUN only, and merge
    // the slice sum into the partial result. The partial result is kept apart
    // from sum_q, so the visible sum only changes when a whole result is ready.
    always_comb begin
        slice_a   = 4'h0;
        slice_b   = 4'h0;
        slice_cin = 1'b0;
        acc_next  = acc_q;
        if (state == RUN) begin
            slice_a   = a_q[{idx, 2'b00} +: 4];
`ifdef SUB_MODE_EN
            slice_b   = sub_q ? ~b_q[{idx, 2'b00} +: 4] : b_q[{idx, 2'b00} +: 4];
`else
            slice_b   = b_q[{idx, 2'b00} +: 4];
`endif
            slice_cin = carry_q;
        end
        acc_next[{idx, 2'b00} +: 4] = slice_s;
    end

    // Sequencer: accept operands, run one slice per cycle, then hold the
    // result until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx     <= '0;
            carry_q <= 1'b0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SUB_MODE_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q   <= a;
                        b_q   <= b;
                        idx   <= '0;
                        state <= RUN;
`ifdef SUB_MODE_EN
                        sub_q   <= sub;
                        carry_q <= sub ? 1'b1 : cin;
`else
                        carry_q <= cin;
`endif
                    end
                end
                RUN: begin
                    acc_q   <= acc_next;
                    carry_q <= slice_cout;
                    if (idx == LAST_IDX) begin
                        sum_q  <= acc_next;
                        cout_q <= slice_cout;
                        idx    <= '0;
                        state  <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: directed bench for adder_seq_ctrl (WIDTH=16). The bench
// supplies a behavioural 4-bit adder slice. Build with SUB_MODE_EN defined to
// also exercise subtraction.
module tb_adder_seq_ctrl;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             sub_r = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic             slice_cin;
    logic [3:0]       slice_s;
    logic             slice_cout;

    int testsRun = 0;
    int testsFailed = 0;

    logic [WIDTH-1:0] resSum;
    logic             resCout;
    int               lat;
    int               idleWait;
    logic [3:0]       cins;
    logic [3:0]       sa0;
    logic [3:0]       sb0;

    adder_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .cin        (cin),
`ifdef SUB_MODE_EN
        .sub        (sub_r),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sum        (sum),
        .cout       (cout),
        .busy       (busy),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_s    (slice_s),
        .slice_cout (slice_cout)
    );

    // External 4-bit ripple slice
    assign {slice_cout, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0000, slice_cin};

    // 200-unit clock period
    always #100 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Hand one operation to the DUT. Record the first nibble pair and the
    // carry-in of each slice pass, then wait (bounded) for out_valid.
    task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic cv, input logic sv,
                                 output logic [WIDTH-1:0] s, output logic c,
                                 output int latency, output logic [3:0] cinSeq,
                                 output logic [3:0] firstA, output logic [3:0] firstB);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!in_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
        a = av;
        b = bv;
        cin = cv;
        sub_r = sv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        firstA = slice_a;
        firstB = slice_b;
        cinSeq = 4'h0;
        latency = 0;
        while (!out_valid && latency < 30) begin
            if (latency < 4) cinSeq[latency] = slice_cin;
            @(posedge clk);
            #1;
            latency++;
        end
        if (!out_valid) checkOutput("done_timeout", 32'd0, 32'd1);
        s = sum;
        c = cout;
    endtask

    // Count cycles until the DUT is back in IDLE (bounded)
    task automatic waitIdle(output int n);
        n = 0;
        while (!in_ready && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) checkOutput("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        // Reset state, sampled between edges while reset is held
        #250;
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_sum_cout", {15'd0, cout, sum}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst_slice", {23'd0, slice_cin, slice_b, slice_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("idle_in_ready", {31'd0, in_ready}, 32'd1);

        // 0x1234 + 0x4321
        applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0, resSum, resCout, lat, cins, sa0, sb0);
        checkOutput("t1_latency", lat, 32'd4);
        checkOutput("t1_sum", {16'd0, resSum}, 32'h5555);
        checkOutput("t1_cout", {31'd0, resCout}, 32'd0);
        checkOutput("t1_first_nibbles", {24'd0, sa0, sb0}, 32'h41);
        waitIdle(idleWait);
        checkOutput("t1_in_ready_low", lat + idleWait, 32'd5);

        // 0xFFFF + 0x0001: carry ripples through every slice
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, resSum, resCout, lat, cins, sa0, sb0);
        checkOutput("t2_cin_seq", {28'd0, cins}, 32'b1110);
        checkOutput("t2_sum", {16'd0, resSum}, 32'h0000);
        checkOutput("t2_cout", {31'd0, resCout}, 32'd1);
        waitIdle(idleWait);

        // 0x7FFF + 0 + cin, then 0x8000 + 0x8000 back-to-back
        applyStimulus(16'h7FFF, 16'h0000, 1'b1, 1'b0, resSum, resCout, lat, cins, sa0, sb0);
        checkOutput("t3a_result", {15'd0, resCout, resSum}, {15'd0, 1'b0, 16'h8000});
        waitIdle(idleWait);
        applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b0, resSum, resCout, lat, cins, sa0, sb0);
        checkOutput("t3b_result", {15'd0, resCout, resSum}, {15'd0, 1'b1, 16'h0000});
        waitIdle(idleWait);

        // Backpressure: hold result in DONE while new operands are offered
        out_ready = 1'b0;
        applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0, resSum, resCout, lat, cins, sa0, sb0);
        checkOutput("t4_sum", {16'd0, resSum}, 32'h3333);
        for (int i = 0; i < 10; i++) begin
            a = 16'hAAAA;
            b = 16'h5555;
            in_valid = (i % 2 == 0);
            @(posedge clk);
            #1;
            checkOutput($sformatf("t4_hold_%0d", i), {12'd0, out_valid, in_ready, busy, cout, sum},
                        {12'd0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h3333});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t4_release", {14'd0, in_ready, out_valid, sum}, {14'd0, 1'b1, 1'b0, 16'h3333});

        // Reset mid-RUN at idx=2, between clock edges
        a = 16'h1234;
        b = 16'h1111;
        cin = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("t5_slice_a_idx2", {28'd0, slice_a}, 32'h2);
        #50;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_flags", {29'd0, out_valid, busy, in_ready}, 32'd0);
        checkOutput("t5_rst_result", {15'd0, cout, sum}, 32'd0);
        checkOutput("t5_rst_slice", {23'd0, slice_cin, slice_b, slice_a}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t5_rst_no_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(16'h0F0F, 16'h00F1, 1'b0, 1'b0, resSum, resCout, lat, cins, sa0, sb0);
        checkOutput("t5_result", {15'd0, resCout, resSum}, {15'd0, 1'b0, 16'h1000});
        waitIdle(idleWait);

`ifdef SUB_MODE_EN
        // Subtraction: cin is ignored when sub=1
        applyStimulus(16'h0007, 16'h0005, 1'b0, 1'b1, resSum, resCout, lat, cins, sa0, sb0);
        checkOutput("t6_sub_pos", {15'd0, resCout, resSum}, {15'd0, 1'b1, 16'h0002});
        waitIdle(idleWait);
        applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1, resSum, resCout, lat, cins, sa0, sb0);
        checkOutput("t6_sub_neg", {15'd0, resCout, resSum}, {15'd0, 1'b0, 16'hFFFE});
        waitIdle(idleWait);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
